// File: rtl/cu_pipe_if.sv
// cu_pipe_if: fetch-side and execute-side handshake bundle for cu_pipe.
//   slave  : view taken by cu_pipe (consumes fetch, produces control bundle)
//   master : view taken by the fetch/execute environment
// Signals: flush, in_valid/in_inst/in_ready (fetch), out_valid/out_ready plus
// control bundle (execute), illegal and err_sticky status.
interface cu_pipe_if #(
  parameter int unsigned OP_W = 6,
  parameter int unsigned RA_W = 4
);
  localparam int unsigned INST_W = OP_W + 3 * RA_W;
  localparam int unsigned IMM_W  = 2 * RA_W;

  logic              flush;
  logic              in_valid;
  logic [INST_W-1:0] in_inst;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        inst_type;
  logic              alu_c_in;
  logic              alu_enable;
  logic              reg_read_a;
  logic              reg_read_b;
  logic              reg_write;
  logic              reg_reset;
  logic [2:0]        wb_sel;
  logic [3:0]        alu_sel;
  logic [RA_W-1:0]   rd;
  logic [RA_W-1:0]   ra;
  logic [RA_W-1:0]   rb;
  logic [IMM_W-1:0]  imm;
  logic              illegal;
  logic              err_sticky;

  modport slave (
    input  flush, in_valid, in_inst, out_ready,
    output in_ready, out_valid, inst_type, alu_c_in, alu_enable, reg_read_a,
           reg_read_b, reg_write, reg_reset, wb_sel, alu_sel, rd, ra, rb, imm,
           illegal, err_sticky
  );

  modport master (
    output flush, in_valid, in_inst, out_ready,
    input  in_ready, out_valid, inst_type, alu_c_in, alu_enable, reg_read_a,
           reg_read_b, reg_write, reg_reset, wb_sel, alu_sel, rd, ra, rb, imm,
           illegal, err_sticky
  );
endinterface

// File: rtl/cu_pipe.sv
// cu_pipe: registered, handshaked instruction decoder. Decodes one
// {opcode, rd, ra, rb} per cycle into a control bundle, holds it until the
// execute stage accepts it, and inserts MC_CYCLES-1 bubbles after shift ops.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : cu_pipe_if.slave (flush, fetch handshake, execute handshake, bundle)
// All bundle/status outputs are registered; bus.in_ready is combinational.
module cu_pipe #(
  parameter int unsigned OP_W      = 6,
  parameter int unsigned RA_W      = 4,
  parameter int unsigned MC_CYCLES = 3
) (
  input  logic      clk,
  input  logic      rst,
  cu_pipe_if.slave  bus
);

  localparam int unsigned INST_W = OP_W + 3 * RA_W;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] BUBBLES = CNT_W'(MC_CYCLES - 1);
  // With a single execute cycle, shifts are ordinary ops and never stall.
  localparam logic HAS_BUBBLES = (MC_CYCLES > 1);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_BUSY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, err_q;
  logic [1:0]        type_q;
  logic              alu_en_q, rda_q, rdb_q, rw_q, ill_q, held_shift_q;
  logic [2:0]        wb_q;
  logic [3:0]        asel_q;
  logic [RA_W-1:0]   rd_q, ra_q, rb_q;

  logic [OP_W-1:0]   op_c;
  logic [RA_W-1:0]   rd_c, ra_c, rb_c;
  logic [1:0]        dec_type_c;
  logic              dec_alu_en_c, dec_rda_c, dec_rdb_c, dec_rw_c;
  logic              dec_ill_c, dec_shift_c, dec_is_alu_c;
  logic [2:0]        dec_wb_c;
  logic [3:0]        dec_asel_c;
  logic              in_ready_c, accept_c;

  assign op_c = bus.in_inst[INST_W-1 -: OP_W];
  assign rd_c = bus.in_inst[3*RA_W-1 -: RA_W];
  assign ra_c = bus.in_inst[2*RA_W-1 -: RA_W];
  assign rb_c = bus.in_inst[RA_W-1:0];

  // Opcode decode of the instruction currently presented by fetch.
  always_comb begin : decode
    dec_type_c   = 2'b00;
    dec_alu_en_c = 1'b0;
    dec_rda_c    = 1'b0;
    dec_rdb_c    = 1'b0;
    dec_rw_c     = 1'b0;
    dec_wb_c     = 3'b000;
    dec_asel_c   = 4'b0000;
    dec_ill_c    = 1'b0;
    dec_shift_c  = 1'b0;
    dec_is_alu_c = 1'b0;
    case (op_c)
      OP_W'(0):  ;
      OP_W'(1):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0000; end
      OP_W'(2):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0001; end
      OP_W'(3):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0010; end
      OP_W'(4):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0011; end
      OP_W'(5):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0100; end
      OP_W'(6):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0101; end
      OP_W'(7):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0110; end
      OP_W'(8):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b0111; end
      OP_W'(9):  begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b1100; end
      OP_W'(10): begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b1001; dec_shift_c = 1'b1; end
      OP_W'(11): begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b1000; dec_shift_c = 1'b1; end
      OP_W'(12): begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b1010; dec_shift_c = 1'b1; end
      OP_W'(13): begin dec_is_alu_c = 1'b1; dec_asel_c = 4'b1011; dec_shift_c = 1'b1; end
      OP_W'(14): begin dec_type_c = 2'b10; dec_rw_c = 1'b1; dec_wb_c = 3'b001; end
      default:   dec_ill_c = 1'b1;
    endcase
    if (dec_is_alu_c) begin
      dec_type_c   = 2'b01;
      dec_alu_en_c = 1'b1;
      dec_rda_c    = 1'b1;
      dec_rdb_c    = (op_c != OP_W'(9));  // INV has a single source
      dec_rw_c     = 1'b1;
    end
  end

  // A held shift blocks the next load even when execute takes it this cycle.
  assign in_ready_c = !bus.flush &&
                      ((state_q == S_EMPTY) ||
                       ((state_q == S_FULL) && bus.out_ready && !held_shift_q));
  assign accept_c   = bus.in_valid && in_ready_c;

  // Next-state logic; flush overrides everything below reset.
  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_EMPTY: if (bus.in_valid) state_d = S_FULL;
      S_FULL: begin
        if (bus.out_ready) begin
          if (held_shift_q) begin
            state_d = S_BUSY;
            cnt_d   = BUBBLES;
          end else if (!bus.in_valid) begin
            state_d = S_EMPTY;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_EMPTY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_EMPTY;
        cnt_d   = '0;
      end
    endcase
    if (bus.flush) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
    end
  end

  // State, bubble counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (state_d == S_FULL);
      err_q       <= err_q | (accept_c & dec_ill_c);
    end
  end

  // Output bundle register, loaded on every accepted instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q       <= 2'b00;
      alu_en_q     <= 1'b0;
      rda_q        <= 1'b0;
      rdb_q        <= 1'b0;
      rw_q         <= 1'b0;
      wb_q         <= 3'b000;
      asel_q       <= 4'b0000;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      ill_q        <= 1'b0;
      held_shift_q <= 1'b0;
    end else if (accept_c) begin
      type_q       <= dec_type_c;
      alu_en_q     <= dec_alu_en_c;
      rda_q        <= dec_rda_c;
      rdb_q        <= dec_rdb_c;
      rw_q         <= dec_rw_c;
      wb_q         <= dec_wb_c;
      asel_q       <= dec_asel_c;
      rd_q         <= rd_c;
      ra_q         <= ra_c;
      rb_q         <= rb_c;
      ill_q        <= dec_ill_c;
      held_shift_q <= dec_shift_c & HAS_BUBBLES;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.inst_type  = type_q;
  assign bus.alu_c_in   = 1'b0;
  assign bus.alu_enable = alu_en_q;
  assign bus.reg_read_a = rda_q;
  assign bus.reg_read_b = rdb_q;
  assign bus.reg_write  = rw_q;
  assign bus.reg_reset  = 1'b0;
  assign bus.wb_sel     = wb_q;
  assign bus.alu_sel    = asel_q;
  assign bus.rd         = rd_q;
  assign bus.ra         = ra_q;
  assign bus.rb         = rb_q;
  assign bus.imm        = {ra_q, rb_q};
  assign bus.illegal    = ill_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_cu_pipe.sv
// tb_cu_pipe: scoreboard bench for cu_pipe (OP_W=6, RA_W=4, MC_CYCLES=3).
module tb_cu_pipe;

  logic clk = 1'b0;
  logic rst;

  cu_pipe_if #(.OP_W(6), .RA_W(4)) bus_if ();

  cu_pipe #(.OP_W(6), .RA_W(4), .MC_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_deliv = 0;
  int n_drop = 0;
  logic err_exp = 1'b0;
  logic [35:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input int op, input int rd, input int ra, input int rb);
    return {6'(op), 4'(rd), 4'(ra), 4'(rb)};
  endfunction

  // Reference decode: {type, c_in, en, rda, rdb, rw, rreset, wb, alu_sel, rd, ra, rb, imm, illegal}
  function automatic logic [35:0] model(input logic [17:0] inst);
    logic [5:0] op;
    logic [1:0] t;
    logic       en, rra, rrb, rw, ill;
    logic [2:0] wb;
    logic [3:0] as;
    op = inst[17:12];
    t = 2'b00; en = 1'b0; rra = 1'b0; rrb = 1'b0; rw = 1'b0; wb = 3'b000;
    case (op)
      6'd1:  as = 4'b0000;
      6'd2:  as = 4'b0001;
      6'd3:  as = 4'b0010;
      6'd4:  as = 4'b0011;
      6'd5:  as = 4'b0100;
      6'd6:  as = 4'b0101;
      6'd7:  as = 4'b0110;
      6'd8:  as = 4'b0111;
      6'd9:  as = 4'b1100;
      6'd10: as = 4'b1001;
      6'd11: as = 4'b1000;
      6'd12: as = 4'b1010;
      6'd13: as = 4'b1011;
      default: as = 4'b0000;
    endcase
    if (op >= 6'd1 && op <= 6'd13) begin
      t = 2'b01; en = 1'b1; rra = 1'b1; rrb = (op != 6'd9); rw = 1'b1;
    end else if (op == 6'd14) begin
      t = 2'b10; rw = 1'b1; wb = 3'b001;
    end
    ill = (op >= 6'd15);
    return {t, 1'b0, en, rra, rrb, rw, 1'b0, wb, as, inst[11:8], inst[7:4], inst[3:0], inst[7:0], ill};
  endfunction

  function automatic logic [35:0] act_bundle();
    return {bus_if.inst_type, bus_if.alu_c_in, bus_if.alu_enable, bus_if.reg_read_a,
            bus_if.reg_read_b, bus_if.reg_write, bus_if.reg_reset, bus_if.wb_sel,
            bus_if.alu_sel, bus_if.rd, bus_if.ra, bus_if.rb, bus_if.imm, bus_if.illegal};
  endfunction

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  always @(negedge clk) begin
    logic [35:0] m;
    if (rst) begin
      sb.delete();
      err_exp = 1'b0;
    end else begin
      chk("err_sticky", bus_if.err_sticky, err_exp);
      if (bus_if.flush) begin
        if (sb.size() != 0) n_drop++;
        sb.delete();
      end else begin
        if (bus_if.out_valid && bus_if.out_ready) begin
          chk("out_expected", (sb.size() != 0), 1'b1);
          if (sb.size() != 0) begin
            m = sb.pop_front();
            chk("bundle", act_bundle(), m);
            n_deliv++;
          end
        end
        if (bus_if.in_valid && bus_if.in_ready) begin
          m = model(bus_if.in_inst);
          sb.push_back(m);
          if (m[0]) err_exp = 1'b1;
          n_acc++;
        end
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) to_drive();
  endtask

  // Present inst until accepted (bounded); returns cycles spent waiting.
  task automatic send(input logic [17:0] inst, input bit rnd, output int waited);
    bus_if.in_valid = 1'b1;
    bus_if.in_inst  = inst;
    waited = 0;
    if (rnd) bus_if.out_ready = ($urandom_range(0, 2) != 0);
    @(negedge clk);
    while (!bus_if.in_ready && waited < 40) begin
      to_drive();
      if (rnd) bus_if.out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      waited++;
    end
    chk("send_accept", bus_if.in_ready, 1'b1);
    to_drive();
    bus_if.in_valid = 1'b0;
  endtask

  initial begin
    int w;
    logic [3:0] exp_ov;
    logic [3:0] exp_ir;

    // Reset with a valid instruction present
    rst = 1'b1;
    bus_if.flush     = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_inst   = mk(1, 1, 2, 3);
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus_if.out_valid, 1'b0);
    chk("rst_bundle", act_bundle(), 36'h0);
    chk("rst_err", bus_if.err_sticky, 1'b0);
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus_if.in_ready, 1'b1);
    chk("rst_out_valid2", bus_if.out_valid, 1'b0);
    to_drive();

    // Back-to-back ADD, SUB, LDIM
    send(mk(1, 1, 2, 3), 1'b0, w);   chk("add_wait", w, 0);
    send(mk(2, 4, 5, 6), 1'b0, w);   chk("sub_wait", w, 0);
    send(mk(14, 7, 10, 5), 1'b0, w); chk("ldim_wait", w, 0);
    @(negedge clk);
    chk("ldim_type", bus_if.inst_type, 2'b10);
    chk("ldim_wb", bus_if.wb_sel, 3'b001);
    chk("ldim_imm", bus_if.imm, 8'hA5);
    idle(3);

    // BSHL then XOR: two bubbles, XOR accepted three edges after BSHL leaves
    send(mk(10, 1, 1, 2), 1'b0, w);
    bus_if.in_valid = 1'b1;
    bus_if.in_inst  = mk(5, 3, 4, 5);
    exp_ov = 4'b0001;  // bit k = cycle k after BSHL load
    exp_ir = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("shift_ov%0d", k), bus_if.out_valid, exp_ov[k]);
      chk($sformatf("shift_ir%0d", k), bus_if.in_ready, exp_ir[k]);
      if (k < 3) to_drive();
    end
    to_drive();
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("xor_held", bus_if.alu_sel, 4'b0100);
    idle(3);

    // Back-pressure holding NAND for 4 cycles
    bus_if.out_ready = 1'b0;
    send(mk(7, 9, 8, 7), 1'b0, w);
    bus_if.in_valid = 1'b1;
    bus_if.in_inst  = mk(3, 2, 2, 2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_ready", bus_if.in_ready, 1'b0);
      chk("hold_valid", bus_if.out_valid, 1'b1);
      chk("hold_bundle", act_bundle(), model(mk(7, 9, 8, 7)));
      to_drive();
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", bus_if.in_ready, 1'b1);
    to_drive();
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("or_loaded", bus_if.alu_sel, 4'b0010);
    chk("or_valid", bus_if.out_valid, 1'b1);
    idle(3);

    // Illegal opcodes and boundaries
    send(mk(63, 1, 2, 3), 1'b0, w);
    @(negedge clk);
    chk("ill_flag", bus_if.illegal, 1'b1);
    chk("ill_err", bus_if.err_sticky, 1'b1);
    chk("ill_nop", bus_if.inst_type, 2'b00);
    to_drive();
    send(mk(1, 3, 3, 3), 1'b0, w);
    @(negedge clk);
    chk("add_after_ill", bus_if.illegal, 1'b0);
    chk("err_stays", bus_if.err_sticky, 1'b1);
    to_drive();
    send(mk(15, 0, 0, 1), 1'b0, w);
    @(negedge clk);
    chk("op15_ill", bus_if.illegal, 1'b1);
    to_drive();
    send(mk(0, 5, 5, 5), 1'b0, w);
    @(negedge clk);
    chk("nop_legal", bus_if.illegal, 1'b0);
    chk("nop_write", bus_if.reg_write, 1'b0);
    to_drive();
    idle(3);

    // Flush while BUSY
    send(mk(11, 1, 2, 3), 1'b0, w);
    to_drive();
    bus_if.flush    = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_inst  = mk(4, 1, 1, 1);
    @(negedge clk);
    chk("flb_ready", bus_if.in_ready, 1'b0);
    chk("flb_valid", bus_if.out_valid, 1'b0);
    to_drive();
    bus_if.flush    = 1'b0;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    chk("flb_after_valid", bus_if.out_valid, 1'b0);
    chk("flb_after_ready", bus_if.in_ready, 1'b1);
    to_drive();
    idle(2);

    // Flush while FULL with a new instruction offered
    bus_if.out_ready = 1'b0;
    send(mk(2, 6, 6, 6), 1'b0, w);
    bus_if.flush    = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.in_inst  = mk(8, 2, 3, 4);
    @(negedge clk);
    chk("flf_ready", bus_if.in_ready, 1'b0);
    to_drive();
    bus_if.flush     = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    chk("flf_after_valid", bus_if.out_valid, 1'b0);
    to_drive();
    idle(3);
    send(mk(1, 2, 2, 2), 1'b0, w);
    idle(3);

    // Random stream with random back-pressure
    for (int i = 0; i < 40; i++) begin
      int op;
      op = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 63) : $urandom_range(0, 14);
      send(mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)), 1'b1, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    bus_if.out_ready = 1'b1;
    idle(8);
    chk("sb_drained", sb.size(), 0);
    chk("count_balance", n_deliv + n_drop, n_acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
